// File: rtl/cpu_pkg.sv
// Shared encodings for the block-move sequencer: operation modes, FSM states
// and default datapath widths.
package cpu_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'b00,
    MODE_FILL  = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/addr_stepper.sv
// Current-address register for one side of a block move: loads a start
// address and steps by +/-1 with natural wrap at 2^ADDR_W.
module addr_stepper #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (step) begin
      addr_d = down ? addr_q - ONE : addr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/reg_block_copy.sv
// Block copy/fill/clear sequencer: walks a register-file range one element per
// cycle, choosing descending order for overlapping copies (memmove semantics).
module reg_block_copy
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_val,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              desc_q, desc_d;

  logic [ADDR_W-1:0] diff, span, src_start, dst_start, cur_src, cur_dst;
  logic              desc_start, load, step;

  // A copy whose destination lies inside the source window must run top-down
  // so no source element is overwritten before it is read.
  assign diff       = dst - src;
  assign span       = ADDR_W'(len - LEN_W'(1));
  assign desc_start = (mode == MODE_COPY) && (dst != src) && (LEN_W'(diff) < len);
  assign src_start  = desc_start ? src + span : src;
  assign dst_start  = desc_start ? dst + span : dst;

  // Steppers are neither loaded for len=0 nor stepped on the final element, so
  // the read address keeps its last value outside RUN.
  assign load = (state_q == ST_IDLE) && start && (len != '0);
  assign step = (state_q == ST_RUN) && (rem_q != LEN_W'(1));

  addr_stepper #(.ADDR_W(ADDR_W)) u_src_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (src_start),
    .step     (step),
    .down     (desc_q),
    .addr     (cur_src)
  );

  addr_stepper #(.ADDR_W(ADDR_W)) u_dst_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (dst_start),
    .step     (step),
    .down     (desc_q),
    .addr     (cur_dst)
  );

  assign rd_addr = cur_src;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    desc_d  = desc_q;
    we      = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          fill_d  = fill_val;
          desc_d  = desc_start;
          rem_d   = len;
          state_d = (len == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        we      = 1'b1;
        wr_addr = cur_dst;
        wr_data = (mode_q == MODE_COPY) ? rd_data :
                  (mode_q == MODE_FILL) ? fill_q  : '0;
        rem_d   = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      desc_q  <= desc_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

endmodule

// File: tb/tb_reg_block_copy.sv
// Scoreboard bench for reg_block_copy with a behavioural register file and a
// memmove-style reference model.
module tb_reg_block_copy;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int LW = 5;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [1:0]    mode;
  logic [AW-1:0] src, dst, rd_addr, wr_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] fill_val, rd_data, wr_data;
  logic          we, busy, done;

  always #5 clk = ~clk;

  reg_block_copy #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // Register file environment, with a backdoor port for preloading
  logic [DW-1:0] regs [N];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  assign rd_data = regs[rd_addr];
  always @(posedge clk) begin
    if (we) regs[wr_addr] <= wr_data;
    else if (bd_we) regs[bd_addr] <= bd_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int d; } wr_t;
  typedef struct { int c; int b; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int  mdl [N];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes / completions whenever the DUT presents them
  initial begin
    int busy_run;
    wr_t ew;
    dn_t ed;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
        if (we !== 1'b0) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0d data %0d", wr_addr, wr_data);
          end else begin
            ew = wq.pop_front();
            chk("wr_addr", int'(wr_addr), ew.a);
            chk("wr_data", int'(wr_data), ew.d);
          end
        end
        if (done !== 1'b0) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: cycle %0d", cyc);
          end else begin
            ed = dq.pop_front();
            chk("done_cycle", cyc, ed.c);
            chk("busy_cycles", busy_run, ed.b);
          end
        end
      end
    end
  end

  task automatic poke(input int a, input int d);
    bd_we = 1'b1; bd_addr = AW'(a); bd_data = DW'(d);
    mdl[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic check_file(input string tag);
    for (int i = 0; i < N; i++) chk({tag, "_reg"}, int'(regs[i]), mdl[i]);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first cycle where the next start is accepted.
  task automatic run_op(input int m, input int s, input int d, input int l,
                        input int fv, input bit mid_start, input int rst_at);
    int snap [N];
    wr_t list[$];
    bit desc, seen;
    int i, n;
    snap = mdl;
    desc = (m == 0) && (d != s) && (((d - s) & (N - 1)) < l);
    for (int k = 0; k < l; k++) begin
      wr_t w;
      i = desc ? l - 1 - k : k;
      w.a = (d + i) % N;
      w.d = (m == 0) ? snap[(s + i) % N] : (m == 1) ? fv : 0;
      list.push_back(w);
    end
    n = (rst_at > 0) ? rst_at : l;
    for (int k = 0; k < n; k++) begin
      wq.push_back(list[k]);
      mdl[list[k].a] = list[k].d;
    end
    if (rst_at == 0) dq.push_back('{c: cyc + 1 + l, b: l + 1});

    start = 1'b1; mode = 2'(m); src = AW'(s); dst = AW'(d);
    len = LW'(l); fill_val = DW'(fv);
    @(negedge clk);
    start = 1'b0; src = AW'($urandom); dst = AW'($urandom);
    fill_val = DW'($urandom); mode = 2'($urandom);

    if (rst_at > 0) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      check_file("after_rst");
      return;
    end

    if (mid_start) begin
      @(negedge clk);
      start = 1'b1; src = AW'(s + 5); dst = AW'(d + 7); len = LW'(2);
      mode = 2'b01;
      @(negedge clk);
      start = 1'b0;
    end

    seen = 1'b0;
    for (int t = 0; t < l + 4; t++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: mode %0d len %0d", m, l);
      repeat (4) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    check_file("contents");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; src = '0; dst = '0; len = '0;
    fill_val = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int a = 0; a < N; a++) poke(a, int'($urandom_range(0, 15)));

    // Plain copy, disjoint ranges
    poke(2, 5); poke(3, 6); poke(4, 7);
    run_op(0, 2, 8, 3, 0, 1'b0, 0);
    // Overlapping copy runs descending
    poke(2, 1); poke(3, 2); poke(4, 3);
    run_op(0, 2, 3, 3, 0, 1'b0, 0);
    // Fill wrapping past the top register
    run_op(1, 0, 14, 4, 9, 1'b0, 0);
    // Zero-length in every mode, then full-file clear
    for (int m = 0; m < 4; m++) run_op(m, 3, 9, 0, 5, 1'b0, 0);
    run_op(2, 0, 0, 16, 0, 1'b0, 0);
    for (int a = 0; a < N; a++) poke(a, int'($urandom_range(0, 15)));
    // src == dst copy leaves contents unchanged
    run_op(0, 5, 5, 4, 0, 1'b0, 0);
    // start during RUN is ignored
    run_op(0, 1, 10, 6, 0, 1'b1, 0);
    // Reset during the second write of a len=5 copy, then a normal op
    run_op(0, 4, 11, 5, 0, 1'b0, 2);
    run_op(0, 11, 0, 5, 0, 1'b0, 0);

    for (int r = 0; r < 40; r++) begin
      int m, l;
      m = int'($urandom_range(0, 3));
      l = (m == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 16));
      run_op(m, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), l,
             int'($urandom_range(0, 15)), 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    chk("pending_writes", wq.size(), 0);
    chk("pending_done", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_block_copy.md
# reg_block_copy

Sequencer for multi-register copy, fill and clear operations. It walks a contiguous range of the datapath register file one element per cycle, driving the file's read port and write port. It replaces the single-shot combinational copy with a start/busy/done handshake, parametrised data and address widths, and overlap-safe (memmove) ordering. It sits beside the ALU and register file and is launched by the control unit on a block-move instruction.

## Interface
Parameters:
- DATA_W, 4, register data width
- ADDR_W, 4, register-file address width (2^ADDR_W registers)
- LEN_W, ADDR_W+1, length field width (allows a full-file length of 2^ADDR_W)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  launch request, sampled only in IDLE
- mode  in  2  operation: 00 COPY, 01 FILL, 10 CLEAR, 11 reserved (treated as CLEAR)
- src  in  ADDR_W  first source register (COPY only)
- dst  in  ADDR_W  first destination register
- len  in  LEN_W  element count
- fill_val  in  DATA_W  constant for FILL
- rd_addr  out  ADDR_W  register-file read address
- rd_data  in  DATA_W  register-file read data, combinational from rd_addr
- we  out  1  register-file write enable
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On start=1, latch mode, fill_val and the direction flag, load the counters, and go to RUN.
  - If len=0, go to FINISH instead.
  - start is ignored in RUN and FINISH.
- Direction: descending when mode=COPY, dst≠src and ((dst−src) mod 2^ADDR_W) < len. Ascending otherwise.
  - Ascending: cur_src=src, cur_dst=dst, with both incrementing.
  - Descending: cur_src=src+len−1, cur_dst=dst+len−1, with both decrementing.
- RUN, each cycle:
  - rd_addr=cur_src.
  - we=1, wr_addr=cur_dst.
  - wr_data is rd_data for COPY, fill_val for FILL, and 0 for CLEAR.
  - Step both addresses and decrement the remaining count.
  - Go to FINISH when remaining count reaches 1.
- FINISH: done=1 for one cycle, then return to IDLE.
- Address arithmetic is modulo 2^ADDR_W; ranges wrap past the top register to register 0.
- len > 2^ADDR_W is not legal; the block performs exactly len writes with wrapped addresses.
- dst=src in COPY: writes are still issued, and the file contents are unchanged.
- rd_addr holds cur_src in RUN and holds its last value otherwise.

## Timing
- Reset values:
  - busy=0, done=0, we=0.
  - rd_addr, wr_addr and wr_data are all 0.
  - State is IDLE.
- Start accepted at edge 0. Writes occur on edges 1..len, with busy=1 for cycles 1..len+1. done pulses in cycle len+1. The next start is accepted in cycle len+2.
- len=0: no writes, busy=1 and done=1 in cycle 1 only.
- The register file commits on the write edge, so a register written in cycle k is visible to the read in cycle k+1. Overlap ordering relies on this.
- we, wr_addr and wr_data are combinational from state and counters; they are valid in the same cycle as rd_addr.
- Reset asserted mid-RUN: we=0 on the next cycle, no further writes, no done pulse, and the FSM is in IDLE.

## Structure
- Shared package (cpu_pkg):
  - mode encodings COPY/FILL/CLEAR
  - FSM state typedef
  - default DATA_W/ADDR_W constants
- Sub-module addr_stepper: holds the current address, loads a start value, and steps ±1 modulo 2^ADDR_W. It is instantiated twice, once for src and once for dst.
- The top level holds the FSM, the remaining counter, the overlap compare and the wr_data mux.

## Test plan
1. COPY, src=2, dst=8, len=3 with R2..R4 = 5,6,7: writes R8=5, R9=6, R10=7 on cycles 1–3, done in cycle 4, no other writes.
2. Overlap, COPY, src=2, dst=3, len=3 with R2..R4 = 1,2,3: descending order, wr_addr sequence 5,4,3, final R3..R5 = 1,2,3.
3. FILL, dst=14, len=4, fill_val=9: wr_addr sequence 14,15,0,1, all wr_data=9.
4. len=0 in any mode: we never asserted, busy and done high in cycle 1 only. Then CLEAR, dst=0, len=16: all 16 registers become 0 and done arrives in cycle 17.
5. start pulsed again mid-RUN with different src/dst: it is ignored and the original sequence completes unchanged.
6. rst_n=0 during the second write of a len=5 COPY: no writes after the reset cycle, no done, outputs at reset values. A new start after release works normally.
